// File: rtl/tx_word_pacer_if.sv
// Handshake and output bundle between the framing layer, the 64b/67b
// encoder/pacer and the downstream 67->20 gearbox.
interface tx_word_pacer_if;
  logic [63:0] S_DATA;
  logic        S_CTRL;
  logic        S_VALID;
  logic        S_READY;
  logic [66:0] DATA_OUT;
  logic        DATA_OUT_VALID;
  logic [15:0] IDLE_CNT;

  // Framing-layer side: drives words in, observes the framed stream.
  modport master (
    output S_DATA, S_CTRL, S_VALID,
    input  S_READY, DATA_OUT, DATA_OUT_VALID, IDLE_CNT
  );

  // Encoder/pacer side.
  modport slave (
    input  S_DATA, S_CTRL, S_VALID,
    output S_READY, DATA_OUT, DATA_OUT_VALID, IDLE_CNT
  );
endinterface

// File: rtl/tx_word_pacer.sv
// Interlaken TX 64b/67b encoder and line-rate pacer.
// Buffers framing-layer words, emits one framed 67-bit word in exactly 20 of
// every 67 cycles (matching a 20 bit/cycle gearbox drain), applies
// disparity-controlled payload inversion, and fills empty slots with an idle
// control word.
module tx_word_pacer #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [63:0] IDLE_WORD  = 64'h8000_0000_0000_0000
) (
  input logic              USER_CLK,
  input logic              SYSTEM_RESET,
  tx_word_pacer_if.slave   bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Buffer storage: {ctrl, payload} per entry.
  logic [64:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  // Pacer residue (0..66) and running disparity.
  logic [6:0]        r_residue;
  logic signed [7:0] r_rd;

  // Output registers.
  logic [66:0] r_data_out;
  logic        r_data_out_valid;
  logic [15:0] r_idle_cnt;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_slot;
  logic              w_pop;
  logic [63:0]       w_payload;
  logic              w_ctrl;
  logic [6:0]        w_pc;
  logic signed [8:0] w_du9;
  logic signed [7:0] w_du;
  logic              w_invert;
  logic [1:0]        w_hdr;
  logic [66:0]       w_enc_word;
  logic signed [7:0] w_rd_next;

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < 64; i++) cnt = cnt + 7'(v[i]);
    return cnt;
  endfunction

  // Full compares the wrap bit too, so the occupancy test needs no counter.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A full buffer refuses a push even when the same edge pops a word.
  assign w_push = bus.S_VALID && !w_full;
  assign w_slot = (r_residue < 7'd20);
  assign w_pop  = w_slot && !w_empty;

  // Encode the word presented at this slot: buffer head, or idle on underrun.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_payload  = IDLE_WORD;
    w_ctrl     = 1'b1;
    if (!w_empty) begin
      w_payload = r_mem[r_rd_ptr[AW-1:0]][63:0];
      w_ctrl    = r_mem[r_rd_ptr[AW-1:0]][64];
    end
    w_pc       = popcount64(w_payload);
    // du = 2*popcount - 64 - 1, range -65..63, never zero.
    w_du9      = $signed({1'b0, w_pc, 1'b0}) - 9'sd65;
    w_du       = $signed(w_du9[7:0]);
    // Invert when the word would push disparity further the same way.
    w_invert   = (r_rd != 8'sd0) && (r_rd[7] == w_du[7]);
    w_hdr      = w_ctrl ? 2'b10 : 2'b01;
    w_enc_word = w_invert ? {1'b1, w_hdr, ~w_payload} : {1'b0, w_hdr, w_payload};
    w_rd_next  = w_invert ? (r_rd - w_du) : (r_rd + w_du);
  end

  // Buffer storage write.
  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are live, so stale contents are never observed.
  always_ff @(posedge USER_CLK) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {bus.S_CTRL, bus.S_DATA};
  end

  // Buffer pointers: push from the framing layer, pop at non-empty slots.
  always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (SYSTEM_RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Free-running pacer: residue steps +47 on a slot, -20 otherwise (mod 67).
  always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) r_residue <= '0;
    else if (w_slot)  r_residue <= r_residue + 7'd47;
    else              r_residue <= r_residue - 7'd20;
  end

  // Output register, running disparity and saturating idle counter.
  always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
      r_idle_cnt       <= '0;
      r_rd             <= '0;
    end else begin
      r_data_out_valid <= w_slot;
      if (w_slot) begin
        r_data_out <= w_enc_word;
        r_rd       <= w_rd_next;
        if (w_empty && (r_idle_cnt != 16'hFFFF)) r_idle_cnt <= r_idle_cnt + 16'd1;
      end
    end
  end

  assign bus.S_READY        = !w_full;
  assign bus.DATA_OUT       = r_data_out;
  assign bus.DATA_OUT_VALID = r_data_out_valid;
  assign bus.IDLE_CNT       = r_idle_cnt;

endmodule

// File: tb/tb_tx_word_pacer.sv
// Scoreboard bench for tx_word_pacer: the driver models each edge from the
// line-rate rule and the encoding rules, queueing expected framed words; a
// separate monitor compares every presented output word against the queue.
module tb_tx_word_pacer;

  localparam logic [63:0] IDLE_WORD = 64'h8000_0000_0000_0000;
  localparam int          DEPTH     = 8;

  typedef struct {
    logic [66:0] word;
    logic [15:0] idle;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tx_word_pacer_if bus();

  tx_word_pacer dut (
    .USER_CLK     (clk),
    .SYSTEM_RESET (rst),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference state.
  logic [64:0] mq[$];     // buffered {ctrl, payload}
  exp_t        exp_q[$];  // expected framed words in order
  int          k_edge;    // edges since reset, mod 67
  int          m_rd;
  int          m_idle;
  logic [66:0] last_out;
  int          pulse_cnt;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [66:0] model_encode(input logic [64:0] w);
    int d, du;
    bit inv;
    logic [1:0] hdr;
    d   = 2 * $countones(w[63:0]) - 64;
    du  = d - 1;
    inv = (m_rd != 0) && ((m_rd < 0) == (du < 0));
    hdr = w[64] ? 2'b10 : 2'b01;
    if (inv) begin
      m_rd = m_rd + (-d + 1);
      return {1'b1, hdr, ~w[63:0]};
    end
    m_rd = m_rd + du;
    return {1'b0, hdr, w[63:0]};
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    k_edge    = 0;
    m_rd      = 0;
    m_idle    = 0;
    last_out  = '0;
    pulse_cnt = 0;
  endtask

  // Called at a falling edge: drive inputs, model the next rising edge, wait.
  task automatic do_cycle(input bit v, input logic [63:0] data, input bit ctrl);
    bit   slot, push;
    exp_t e;
    bus.S_VALID = v;
    bus.S_DATA  = data;
    bus.S_CTRL  = ctrl;
    check("s_ready", 67'(bus.S_READY), 67'(mq.size() < DEPTH));
    slot   = ((47 * k_edge) % 67) < 20;
    k_edge = (k_edge + 1) % 67;
    push   = v && (mq.size() < DEPTH);
    if (slot) begin
      logic [64:0] w;
      if (mq.size() > 0) w = mq.pop_front();
      else begin
        w = {1'b1, IDLE_WORD};
        if (m_idle < 65535) m_idle++;
      end
      e.word = model_encode(w);
      e.idle = 16'(m_idle);
      exp_q.push_back(e);
    end
    if (push) mq.push_back({ctrl, data});
    @(negedge clk);
  endtask

  task automatic apply_reset();
    bus.S_VALID = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 67'(bus.DATA_OUT_VALID), 67'(0));
    check("rst_data",  bus.DATA_OUT, 67'(0));
    check("rst_idle",  67'(bus.IDLE_CNT), 67'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: after each rising edge, compare any presented word; otherwise
  // DATA_OUT must hold its last value.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (bus.DATA_OUT_VALID) begin
          pulse_cnt++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_word: got %h expected none at %0t", bus.DATA_OUT, $time);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("data_out", bus.DATA_OUT, e.word);
            check("idle_cnt", 67'(bus.IDLE_CNT), 67'(e.idle));
            last_out = e.word;
          end
        end else begin
          check("data_hold", bus.DATA_OUT, last_out);
        end
      end
    end
  end

  initial begin
    bus.S_VALID = 1'b0;
    bus.S_DATA  = '0;
    bus.S_CTRL  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_valid", 67'(bus.DATA_OUT_VALID), 67'(0));
    check("reset_data",  bus.DATA_OUT, 67'(0));
    check("reset_idle",  67'(bus.IDLE_CNT), 67'(0));
    check("reset_ready", 67'(bus.S_READY), 67'(1));
    rst = 1'b0;

    // No input for 134 cycles: 40 idle words.
    repeat (134) do_cycle(1'b0, 64'h0, 1'b0);
    check("idle_pulses", 67'(pulse_cnt), 67'(40));
    check("idle_cnt_40", 67'(bus.IDLE_CNT), 67'(40));

    // Unbalanced all-ones data stream, buffer fills.
    repeat (60) do_cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    // Balanced data stream.
    repeat (60) do_cycle(1'b1, 64'h0000_0000_FFFF_FFFF, 1'b0);
    // Drain to empty.
    repeat (40) do_cycle(1'b0, 64'h0, 1'b0);
    // Burst of distinct words with valid held; buffer goes full.
    for (int i = 1; i <= 30; i++) do_cycle(1'b1, 64'(i), 1'b0);
    // Random traffic.
    repeat (300) do_cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 1) == 1);

    // Mid-stream reset, then a push coincident with the first (empty) slot.
    apply_reset();
    do_cycle(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0);
    repeat (20) do_cycle(1'b0, 64'h0, 1'b0);
    repeat (300) do_cycle($urandom_range(0, 1) == 1, {$urandom, $urandom}, $urandom_range(0, 3) == 0);

    check("scoreboard_drained", 67'(exp_q.size()), 67'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
